// File: rtl/cordic_sine_sequencer_if.sv
// rtl/cordic_sine_sequencer_if.sv - CORDIC request/response and sine result stream bundle
//
// Purpose: groups the two handshakes of the sequencer into one bundle.
// Ports (master = sequencer side):
//   cor_start  out  one-cycle request pulse to the CORDIC core
//   cor_angle  out  angle <int,15>, held from cor_start until cor_valid
//   cor_sine   in   sine result <int,15> from the core
//   cor_valid  in   one-cycle result strobe from the core
//   out_data   out  FIFO head sine sample
//   out_last   out  head is the final sample of the run
//   out_valid  out  FIFO non-empty
//   out_ready  in   consumer accepts the head (pop = out_valid & out_ready)
interface cordic_sine_sequencer_if;
  logic        cor_start;
  logic [31:0] cor_angle;
  logic [31:0] cor_sine;
  logic        cor_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output cor_start, cor_angle, out_data, out_last, out_valid,
    input  cor_sine, cor_valid, out_ready
  );

  modport slave (
    input  cor_start, cor_angle, out_data, out_last, out_valid,
    output cor_sine, cor_valid, out_ready
  );
endinterface

// File: rtl/cordic_sine_sequencer.sv
// rtl/cordic_sine_sequencer.sv - phase-ramp driver for an iterative CORDIC sine core with result FIFO
//
// Purpose: generates a wrapped phase ramp, issues one CORDIC request per
// sample, waits (with watchdog) for the result and queues it for a
// valid/ready consumer.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   cfg_load   in   latch cfg_step/cfg_count while idle
//   cfg_step   in   phase increment <int,15>, 0..0x3243F
//   cfg_count  in   samples per run (0 makes go a no-op)
//   go         in   start a run from idle
//   abort      in   stop run and flush the FIFO
//   busy       out  run in progress
//   err        out  sticky watchdog timeout flag
//   bus        master side of cordic_sine_sequencer_if (core + result stream)
module cordic_sine_sequencer #(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_load,
  input  logic [31:0]             cfg_step,
  input  logic [CNT_W-1:0]        cfg_count,
  input  logic                    go,
  input  logic                    abort,
  output logic                    busy,
  output logic                    err,
  cordic_sine_sequencer_if.master bus
);

  localparam int AW   = $clog2(DEPTH);
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  localparam logic [32:0]      TWO_PI    = 33'h0_0003_243F;
  localparam logic [AW:0]      FIFO_FULL = (AW+1)'(DEPTH);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state;
  logic [31:0]      step_reg;
  logic [CNT_W-1:0] count_reg;
  logic [31:0]      phase;
  logic [CNT_W-1:0] remaining;
  logic [WD_W-1:0]  wdog;
  logic             cor_start_r;

  logic [32:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      fifo_cnt;

  logic             go_ok;
  logic             push;
  logic             pop;
  logic             last_sample;
  logic [32:0]      phase_sum;
  logic [31:0]      phase_next;

  // Phase ramp wraps at 2pi so the core never sees an angle >= 2pi.
  always_comb begin
    phase_sum  = {1'b0, phase} + {1'b0, step_reg};
    phase_next = phase_sum[31:0];
    if (phase_sum >= TWO_PI) begin
      phase_next = 32'(phase_sum - TWO_PI);
    end
  end

  assign go_ok       = (state == IDLE) && go && (count_reg != '0);
  assign last_sample = (remaining == CNT_ONE);
  // abort wins over any FIFO traffic in the same cycle
  assign push        = (state == WAIT) && bus.cor_valid && !abort;
  assign pop         = (fifo_cnt != '0) && bus.out_ready && !abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      step_reg    <= '0;
      count_reg   <= '0;
      phase       <= '0;
      remaining   <= '0;
      wdog        <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      cor_start_r <= 1'b0;
    end else begin
      cor_start_r <= 1'b0;

      // A load coinciding with an accepted go belongs to the next run, so
      // the run never mixes an old count with a new step.
      if (cfg_load && (state == IDLE) && !go_ok) begin
        step_reg  <= cfg_step;
        count_reg <= cfg_count;
      end

      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (go_ok) begin
              state     <= ISSUE;
              phase     <= '0;
              remaining <= count_reg;
              err       <= 1'b0;
              busy      <= 1'b1;
            end
          end

          ISSUE: begin
            // Only issue when the result is guaranteed a FIFO slot.
            if (fifo_cnt < FIFO_FULL) begin
              cor_start_r <= 1'b1;
              wdog        <= '0;
              state       <= WAIT;
            end
          end

          WAIT: begin
            wdog <= wdog + WD_W'(1);
            if (bus.cor_valid) begin
              phase     <= phase_next;
              remaining <= remaining - CNT_ONE;
              if (last_sample) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= ISSUE;
              end
            end else if (wdog == WD_LAST) begin
              err   <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted in.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {last_sample, bus.cor_sine};
    end
  end

  assign bus.cor_start = cor_start_r;
  assign bus.cor_angle = phase;
  assign bus.out_valid = (fifo_cnt != '0);
  // Gated so the stream reads as zero when empty (including after reset).
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr][31:0] : 32'h0;
  assign bus.out_last  = bus.out_valid & mem[rd_ptr][32];

endmodule

// File: tb/tb_cordic_sine_sequencer.sv
// tb/tb_cordic_sine_sequencer.sv - directed self-checking bench for cordic_sine_sequencer
module tb_cordic_sine_sequencer;

  logic        clk;
  logic        rst;
  logic        cfg_load;
  logic [31:0] cfg_step;
  logic [15:0] cfg_count;
  logic        go;
  logic        abort;
  logic        busy;
  logic        err;

  cordic_sine_sequencer_if bus ();

  cordic_sine_sequencer #(.DEPTH(4), .CNT_W(16), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_load  (cfg_load),
    .cfg_step  (cfg_step),
    .cfg_count (cfg_count),
    .go        (go),
    .abort     (abort),
    .busy      (busy),
    .err       (err),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_near(input string tag, input logic [31:0] obs, input int exp, input int tol);
    int d;
    d = int'(obs) - exp;
    n_chk++;
    assert ((d <= tol) && (d >= -tol)) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, int'(obs), exp, tol);
  endtask

  // CORDIC core model: responds core_lat negedges after seeing cor_start.
  int          core_lat  = 3;
  bit          core_echo = 1'b0;
  bit          core_mute = 1'b0;
  int          pend      = 0;
  logic [31:0] pend_res  = '0;
  logic [31:0] held_ang  = '0;
  int          n_start   = 0;
  int          over_cnt  = 0;
  logic [31:0] angle_log[$];
  logic [32:0] out_log[$];

  function automatic logic [31:0] core_fn(input logic [31:0] a);
    real r;
    if (core_echo) return a + 32'h100;
    r = $sin(real'(a) / 32768.0) * 32768.0;
    return int'(r);
  endfunction

  always @(negedge clk) begin
    bus.cor_valid = 1'b0;
    bus.cor_sine  = pend_res;
    if (pend > 0) begin
      if (busy) chk("angle_stable", bus.cor_angle, held_ang);
      pend = pend - 1;
      if (pend == 0) bus.cor_valid = 1'b1;
    end
    if (bus.cor_start === 1'b1) begin
      n_start++;
      angle_log.push_back(bus.cor_angle);
      if (bus.cor_angle >= 32'h3243F) over_cnt++;
      if (!core_mute) begin
        pend     = core_lat;
        pend_res = core_fn(bus.cor_angle);
        held_ang = bus.cor_angle;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
      out_log.push_back({bus.out_last, bus.out_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [31:0] step, input logic [15:0] cnt);
    cfg_load  = 1'b1;
    cfg_step  = step;
    cfg_count = cnt;
    tick();
    cfg_load = 1'b0;
    go       = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    chk(tag, busy, 1'b0);
  endtask

  task automatic clear_logs();
    angle_log.delete();
    out_log.delete();
    n_start = 0;
  endtask

  logic [31:0] exp_a1 [4] = '{32'h0, 32'hC90F, 32'h1921E, 32'h25B2D};
  int          exp_s1 [4] = '{0, 32768, 0, -32768};
  logic [31:0] exp_a2 [3] = '{32'h0, 32'h30000, 32'h2DBC1};

  initial begin
    int k;
    rst           = 1'b1;
    cfg_load      = 1'b0;
    cfg_step      = '0;
    cfg_count     = '0;
    go            = 1'b0;
    abort         = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_cor_start", bus.cor_start, 1'b0);
    chk("rst_cor_angle", bus.cor_angle, 32'h0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_out_last", bus.out_last, 1'b0);
    rst = 1'b0;
    tick();

    // 1: quarter steps, consumer always ready
    clear_logs();
    core_echo = 1'b0;
    core_lat  = 3;
    run(32'hC90F, 16'd4);
    chk("t1_busy_after_go", busy, 1'b1);
    wait_idle("t1_done", 200);
    repeat (3) tick();
    chk("t1_nstart", angle_log.size(), 4);
    chk("t1_nout", out_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_angle%0d", i), angle_log[i], exp_a1[i]);
      chk_near($sformatf("t1_sine%0d", i), out_log[i][31:0], exp_s1[i], 8);
      chk($sformatf("t1_last%0d", i), out_log[i][32], (i == 3));
    end
    chk("t1_busy_end", busy, 1'b0);

    // 2: wrap at 2pi
    clear_logs();
    run(32'h30000, 16'd3);
    wait_idle("t2_done", 200);
    repeat (3) tick();
    chk("t2_nstart", angle_log.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("t2_angle%0d", i), angle_log[i], exp_a2[i]);
    chk("t2_no_angle_over", over_cnt, 0);

    // 3: backpressure fills the FIFO, then drains in order
    clear_logs();
    core_echo     = 1'b1;
    bus.out_ready = 1'b0;
    run(32'h1000, 16'd6);
    repeat (40) tick();
    chk("t3_starts_stalled", n_start, 4);
    chk("t3_busy_stalled", busy, 1'b1);
    chk("t3_head_data", bus.out_data, 32'h100);
    chk("t3_head_last", bus.out_last, 1'b0);
    cfg_load  = 1'b1;
    cfg_step  = 32'h9999;
    cfg_count = 16'd1;
    tick();
    cfg_load = 1'b0;
    repeat (10) tick();
    chk("t3_starts_still", n_start, 4);
    chk("t3_head_held", bus.out_data, 32'h100);
    bus.out_ready = 1'b1;
    wait_idle("t3_done", 300);
    repeat (4) tick();
    chk("t3_nstart", n_start, 6);
    chk("t3_nout", out_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3_angle%0d", i), angle_log[i], 32'(i * 32'h1000));
      chk($sformatf("t3_data%0d", i), out_log[i][31:0], 32'(i * 32'h1000 + 32'h100));
      chk($sformatf("t3_last%0d", i), out_log[i][32], (i == 5));
    end

    // 4: watchdog timeout, then go clears err
    clear_logs();
    core_mute = 1'b1;
    run(32'h1000, 16'd2);
    k = 0;
    while (bus.cor_start !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    chk("t4_start_seen", bus.cor_start, 1'b1);
    k = 0;
    do begin
      tick();
      k++;
    end while (!err && k < 200);
    chk("t4_timeout_cycles", k, 64);
    chk("t4_err", err, 1'b1);
    chk("t4_busy", busy, 1'b0);
    core_mute = 1'b0;
    run(32'h1000, 16'd1);
    chk("t4_err_cleared", err, 1'b0);
    wait_idle("t4_rerun_done", 100);
    repeat (3) tick();

    // 5: abort mid-WAIT with two samples queued
    clear_logs();
    core_lat      = 6;
    bus.out_ready = 1'b0;
    run(32'h1000, 16'd4);
    k = 0;
    while (n_start < 3 && k < 100) begin
      tick();
      k++;
    end
    chk("t5_third_issue", n_start, 3);
    chk("t5_fifo_nonempty", bus.out_valid, 1'b1);
    chk("t5_head", bus.out_data, 32'h100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_busy", busy, 1'b0);
    chk("t5_out_valid", bus.out_valid, 1'b0);
    chk("t5_err_kept", err, 1'b0);
    repeat (15) tick();
    chk("t5_late_valid_ignored", bus.out_valid, 1'b0);
    chk("t5_no_reissue", n_start, 3);

    // 6: reset in WAIT, then go with count 0
    clear_logs();
    run(32'h1000, 16'd4);
    k = 0;
    while (n_start < 3 && k < 100) begin
      tick();
      k++;
    end
    chk("t6_third_issue", n_start, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", busy, 1'b0);
    chk("t6_err", err, 1'b0);
    chk("t6_cor_start", bus.cor_start, 1'b0);
    chk("t6_cor_angle", bus.cor_angle, 32'h0);
    chk("t6_out_valid", bus.out_valid, 1'b0);
    chk("t6_out_data", bus.out_data, 32'h0);
    chk("t6_out_last", bus.out_last, 1'b0);
    repeat (15) tick();
    chk("t6_late_valid_ignored", bus.out_valid, 1'b0);
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("t6_go_after_rst_idle", busy, 1'b0);
    run(32'h1000, 16'd0);
    chk("t6_go_count0_idle", busy, 1'b0);
    tick();
    chk("t6_no_issue", n_start, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
